// File: rtl/cube_vertex_rotator.sv
`timescale 1ns/1ps
// cube_vertex_rotator
//
// Latches a signed fixed-point 3x3 rotation matrix and walks the 8 vertices
// of an origin-centred cube with half-edge HALF. Each vertex takes three CALC
// cycles, one matrix row per cycle. The rotated vertex is then offered on a
// valid/ready stream.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   mat        matrix, mat[r][c] is row r / column c (Q1.FRAC, signed)
//   start      begin an 8-vertex pass (honoured only in IDLE)
//   busy       high in every state except IDLE
//   out_valid  rotated vertex available
//   out_ready  consumer accepts the vertex
//   out_x/y/z  signed rotated coordinates (floor-shifted, saturated)
//   out_idx    vertex index 0..7
//   out_last   high together with out_valid for vertex 7
//   done       one-cycle pulse after vertex 7 is accepted
//   dbg_state  current FSM state (0 IDLE, 1 CALC, 2 OUT)
//
// Handshake: a vertex transfers at the rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low, every
// out_* signal holds its value. out_valid never depends combinationally on
// out_ready. out_valid always drops after a transfer, because the next vertex
// needs three more CALC cycles.

module cube_vertex_rotator #(
  parameter int IN_BITS  = 8,
  parameter int FRAC     = 6,
  parameter int HALF     = 40,
  parameter int OUT_BITS = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [2:0][2:0][IN_BITS-1:0]        mat,
  input  logic                                start,
  output logic                                busy,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [OUT_BITS-1:0]          out_x,
  output logic signed [OUT_BITS-1:0]          out_y,
  output logic signed [OUT_BITS-1:0]          out_z,
  output logic [2:0]                          out_idx,
  output logic                                out_last,
  output logic                                done,
  output logic [1:0]                          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam int PROD_W = 2 * IN_BITS;
  localparam int ACC_W  = 2 * IN_BITS + 2;

  localparam logic signed [IN_BITS-1:0] V_POS   = IN_BITS'(HALF);
  localparam logic signed [IN_BITS-1:0] V_NEG   = IN_BITS'(-HALF);
  localparam logic signed [ACC_W-1:0]   SAT_MAX = ACC_W'((2 ** (OUT_BITS - 1)) - 1);
  localparam logic signed [ACC_W-1:0]   SAT_MIN = ACC_W'(-(2 ** (OUT_BITS - 1)));

  state_t                        state;
  logic [2:0][2:0][IN_BITS-1:0]  mat_q;
  logic [1:0]                    row;
  logic [2:0]                    idx;

  logic signed [IN_BITS-1:0]     vtx  [3];
  logic signed [PROD_W-1:0]      prod [3];
  logic signed [ACC_W-1:0]       acc;
  logic signed [ACC_W-1:0]       acc_sh;
  logic signed [OUT_BITS-1:0]    row_res;

  // Dot product of the current matrix row with the current vertex. The
  // vertex coordinate signs come straight from the index bits (bit0 = x).
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      vtx[c]  = idx[c] ? V_POS : V_NEG;
      prod[c] = $signed(mat_q[row][c]) * vtx[c];
    end
    acc    = ACC_W'(prod[0]) + ACC_W'(prod[1]) + ACC_W'(prod[2]);
    // Arithmetic shift gives floor rounding for negative sums.
    acc_sh = acc >>> FRAC;
    if (acc_sh > SAT_MAX) begin
      row_res = SAT_MAX[OUT_BITS-1:0];
    end else if (acc_sh < SAT_MIN) begin
      row_res = SAT_MIN[OUT_BITS-1:0];
    end else begin
      row_res = acc_sh[OUT_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      mat_q     <= '0;
      row       <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mat_q <= mat;
            idx   <= '0;
            row   <= '0;
            busy  <= 1'b1;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          case (row)
            2'd0:    out_x <= row_res;
            2'd1:    out_y <= row_res;
            default: out_z <= row_res;
          endcase
          if (row == 2'd2) begin
            row       <= '0;
            out_valid <= 1'b1;
            out_last  <= (idx == 3'd7);
            state     <= S_OUT;
          end else begin
            row <= row + 2'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (idx == 3'd7) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              idx   <= idx + 3'd1;
              row   <= '0;
              state <= S_CALC;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_idx   = idx;
  assign dbg_state = state;

endmodule

// File: tb/tb_cube_vertex_rotator.sv
`timescale 1ns/1ps
// Bench for cube_vertex_rotator: directed matrices, a vertex scoreboard fed
// from an integer reference, and hand-computed spot values.

module tb_cube_vertex_rotator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT (HALF = 40) ----------------
  logic [2:0][2:0][7:0] mat;
  logic                 start, out_ready;
  logic                 busy, out_valid, out_last, done;
  logic signed [9:0]    out_x, out_y, out_z;
  logic [2:0]           out_idx;
  logic [1:0]           dbg_state;

  cube_vertex_rotator u_dut (
    .clk(clk), .rst(rst), .mat(mat), .start(start), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_y(out_y), .out_z(out_z), .out_idx(out_idx), .out_last(out_last),
    .done(done), .dbg_state(dbg_state)
  );

  // ---------------- saturation DUT (HALF = 127) ----------------
  logic [2:0][2:0][7:0] mat_s;
  logic                 start_s, rdy_s;
  logic                 busy_s, valid_s, last_s, done_s;
  logic signed [9:0]    x_s, y_s, z_s;
  logic [2:0]           idx_s;
  logic [1:0]           dbg_s;

  cube_vertex_rotator #(.HALF(127)) u_sat (
    .clk(clk), .rst(rst), .mat(mat_s), .start(start_s), .busy(busy_s),
    .out_valid(valid_s), .out_ready(rdy_s), .out_x(x_s),
    .out_y(y_s), .out_z(z_s), .out_idx(idx_s), .out_last(last_s),
    .done(done_s), .dbg_state(dbg_s)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [33:0] exp_q[$];        // {last, idx, x, y, z}
  logic [29:0] obs   [8];
  logic [29:0] obs_s [8];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] pk(input int x, input int y, input int z);
    return {10'(x), 10'(y), 10'(z)};
  endfunction

  function automatic logic [2:0][2:0][7:0] m_ident();
    logic [2:0][2:0][7:0] m;
    m = '0;
    m[0][0] = 8'd64; m[1][1] = 8'd64; m[2][2] = 8'd64;
    return m;
  endfunction

  function automatic logic [2:0][2:0][7:0] m_rotz();
    logic [2:0][2:0][7:0] m;
    m = '0;
    m[0][1] = 8'hC0; m[1][0] = 8'd64; m[2][2] = 8'd64;
    return m;
  endfunction

  // Integer reference: floor shift by 6, clamp to 10-bit signed.
  function automatic logic [33:0] model(input logic [2:0][2:0][7:0] m, input int half, input int i);
    int v [3];
    int acc;
    logic [9:0] o [3];
    for (int c = 0; c < 3; c++) v[c] = i[c] ? half : -half;
    for (int r = 0; r < 3; r++) begin
      acc = 0;
      for (int c = 0; c < 3; c++) acc += int'($signed(m[r][c])) * v[c];
      acc = acc >>> 6;
      if (acc > 511) acc = 511;
      if (acc < -512) acc = -512;
      o[r] = 10'(acc);
    end
    return {(i == 7), 3'(i), o[0], o[1], o[2]};
  endfunction

  task automatic fill_queue(input logic [2:0][2:0][7:0] m);
    for (int i = 0; i < 8; i++) exp_q.push_back(model(m, 40, i));
  endtask

  // ---------------- driver: one full pass on u_dut ----------------
  // k counts rising edges after the start edge; samples are taken at the
  // falling edge following edge k.
  task automatic run_pass(input string name, input int stall_vtx, input int stall_len,
                          input int poke_k, input int exp_done_k);
    int          stall_left;
    int          first_valid_k;
    logic        held, seen_done;
    logic [34:0] held_v;
    logic [33:0] e;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({name, "_busy_rise"}, busy, 1);
    stall_left = stall_len; held = 1'b0; seen_done = 1'b0; first_valid_k = -1;
    for (int k = 0; k <= 100; k++) begin
      if (held)
        chk({name, "_hold"}, {out_valid, out_last, out_idx, out_x, out_y, out_z}, held_v);
      if (out_valid && first_valid_k < 0) first_valid_k = k;
      if (done) begin
        seen_done = 1'b1;
        chk({name, "_done_cycle"}, k, exp_done_k);
        chk({name, "_busy_at_done"}, busy, 0);
        chk({name, "_valid_at_done"}, out_valid, 0);
        chk({name, "_idx_hold"}, out_idx, 7);
        break;
      end
      if (out_valid && int'(out_idx) == stall_vtx && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        obs[out_idx] = {out_x, out_y, out_z};
        if (exp_q.size() == 0) chk({name, "_sb_underflow"}, 1, 0);
        else begin
          e = exp_q.pop_front();
          chk({name, "_vtx"}, {out_last, out_idx, out_x, out_y, out_z}, e);
        end
      end
      held   = out_valid && !out_ready;
      held_v = {out_valid, out_last, out_idx, out_x, out_y, out_z};
      if (k == poke_k) begin
        start = 1'b1;
        mat   = {9{8'h25}};
      end else if (k == poke_k + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk({name, "_done_seen"}, seen_done, 1);
    chk({name, "_first_valid"}, first_valid_k, 3);
    chk({name, "_sb_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_valid"}, out_valid, 0);
    chk({name, "_last"}, out_last, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_xyz"}, {out_x, out_y, out_z}, 0);
    chk({name, "_idx"}, out_idx, 0);
    chk({name, "_state"}, dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic seen;
    rst = 1'b1; start = 1'b0; start_s = 1'b0; out_ready = 1'b1; rdy_s = 1'b1;
    mat = m_ident(); mat_s = {9{8'd127}};
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst0");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // identity
    fill_queue(m_ident());
    run_pass("ident", -1, 0, -1, 32);
    chk("ident_v0", obs[0], pk(-40, -40, -40));
    chk("ident_v5", obs[5], pk(40, -40, 40));
    chk("ident_v7", obs[7], pk(40, 40, 40));

    // 90 degrees about z
    mat = m_rotz();
    fill_queue(m_rotz());
    run_pass("rotz", -1, 0, -1, 32);
    chk("rotz_v0", obs[0], pk(40, -40, -40));
    chk("rotz_v1", obs[1], pk(40, 40, -40));
    chk("rotz_v6", obs[6], pk(-40, -40, 40));

    // backpressure on vertex 2
    mat = m_ident();
    fill_queue(m_ident());
    run_pass("bp", 2, 5, -1, 37);

    // start and matrix change mid-pass are ignored
    mat = m_rotz();
    fill_queue(m_rotz());
    run_pass("poke", -1, 0, 10, 32);
    chk("poke_v1", obs[1], pk(40, 40, -40));
    mat = m_ident();

    // saturation instance
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (valid_s) obs_s[idx_s] = {x_s, y_s, z_s};
      if (done_s) seen = 1'b1;
      @(negedge clk);
    end
    chk("sat_done", seen, 1);
    chk("sat_v7", obs_s[7], pk(511, 511, 511));
    chk("sat_v0", obs_s[0], pk(-512, -512, -512));
    chk("sat_v3", obs_s[3], pk(252, 252, 252));
    chk("sat_v1", obs_s[1], pk(-253, -253, -253));

    // start in the done cycle, then reset while vertex 4 is offered
    fill_queue(m_ident());
    run_pass("chain", -1, 0, -1, 32);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("chain_busy", busy, 1);
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (out_valid && out_idx == 3'd4) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("chain_reach_v4", seen, 1);
    out_ready = 1'b0;
    chk("pre_rst_state", dbg_state, 2);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk); rst = 1'b1;
    out_ready = 1'b1;
    fill_queue(m_ident());
    run_pass("after_rst", -1, 0, -1, 32);
    chk("after_rst_v0", obs[0], pk(-40, -40, -40));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
